instruction_fetch: RTL and testbench

Fetch-stage initiator for the single-cycle-read instruction memory. It owns the program counter and drives the word address into the instruction memory. It captures the returned instruction into the IF/ID pipeline register. It also handles stall, branch/jump redirect, halt and a fetched-instruction counter.

---
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage for a single-cycle-read instruction memory.
// It holds the program counter and drives the word address to the memory.
// The returned word is captured into the IF/ID register. The stage also
// handles decode stalls, branch/jump redirects, halt, a sticky
// misaligned-target flag and a count of fetched instructions.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID (ignored while halted)
//   redirect_valid    taken branch/jump; redirect_pc is its byte target
//   halt_req          stop fetching (enter HALTED)
//   imem_address      word address to memory, pc[ADDR_WIDTH+1:2]
//   imem_instruction  word returned for imem_address in the same cycle
//   ifid_*            IF/ID register: instruction, pc, pc+4, valid
//   halted            FSM is in HALTED
//   misalign_fault    sticky: a redirect target was not word aligned
//   fetch_count       number of valid instructions loaded into IF/ID
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  output logic [DATA_WIDTH-1:0] ifid_instruction,
  output logic [DATA_WIDTH-1:0] ifid_pc,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic                  misalign_fault,
  output logic [DATA_WIDTH-1:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] redirect_aligned;
  logic                  redirect_misaligned;
  logic [DATA_WIDTH-1:0] instruction_next;
  logic [DATA_WIDTH-1:0] ifid_pc_next;
  logic [DATA_WIDTH-1:0] ifid_pc_plus4_next;
  logic                  ifid_valid_next;
  logic                  misalign_next;
  logic [DATA_WIDTH-1:0] fetch_count_next;

  // Upper PC bits are not decoded, so fetch addressing wraps within memory.
  assign imem_address        = pc[ADDR_WIDTH+1:2];
  assign pc_plus4            = pc + DATA_WIDTH'(4);
  assign redirect_aligned    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign halted              = (state == HALTED);

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    instruction_next   = ifid_instruction;
    ifid_pc_next       = ifid_pc;
    ifid_pc_plus4_next = ifid_pc_plus4;
    ifid_valid_next    = ifid_valid;
    misalign_next      = misalign_fault;
    fetch_count_next   = fetch_count;

    case (state)
      RUN: begin
        if (redirect_valid) begin
          // Redirect wins over stall and halt and leaves a single bubble.
          pc_next            = redirect_aligned;
          instruction_next   = '0;
          ifid_pc_next       = '0;
          ifid_pc_plus4_next = '0;
          ifid_valid_next    = 1'b0;
          misalign_next      = misalign_fault | redirect_misaligned;
        end else if (stall) begin
          // Hold everything.
        end else if (halt_req) begin
          state_next         = HALTED;
          instruction_next   = '0;
          ifid_pc_next       = '0;
          ifid_pc_plus4_next = '0;
          ifid_valid_next    = 1'b0;
        end else begin
          instruction_next   = imem_instruction;
          ifid_pc_next       = pc;
          ifid_pc_plus4_next = pc_plus4;
          ifid_valid_next    = 1'b1;
          pc_next            = pc_plus4;
          fetch_count_next   = fetch_count + DATA_WIDTH'(1);
        end
      end
      HALTED: begin
        // Stall is ignored here; only a redirect restarts fetching.
        instruction_next   = '0;
        ifid_pc_next       = '0;
        ifid_pc_plus4_next = '0;
        ifid_valid_next    = 1'b0;
        if (redirect_valid) begin
          state_next    = RUN;
          pc_next       = redirect_aligned;
          misalign_next = misalign_fault | redirect_misaligned;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= RUN;
      pc               <= RESET_PC;
      ifid_instruction <= '0;
      ifid_pc          <= '0;
      ifid_pc_plus4    <= '0;
      ifid_valid       <= 1'b0;
      misalign_fault   <= 1'b0;
      fetch_count      <= '0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      ifid_instruction <= instruction_next;
      ifid_pc          <= ifid_pc_next;
      ifid_pc_plus4    <= ifid_pc_plus4_next;
      ifid_valid       <= ifid_valid_next;
      misalign_fault   <= misalign_next;
      fetch_count      <= fetch_count_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch. Memory word k
// holds 32'h1000_0000 + k. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [9:0]  imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic        misalign_fault;
  logic [31:0] fetch_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  instruction_fetch #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .ifid_instruction(ifid_instruction),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .misalign_fault  (misalign_fault),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  assign imem_instruction = 32'h1000_0000 + {22'd0, imem_address};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rv,
                       input logic [31:0] rpc, input logic hr);
    reset          = rst;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] pc_exp,
                             input logic [31:0] word_exp, input logic [31:0] cnt_exp);
    check_val({tag, ".instr"}, ifid_instruction, word_exp);
    check_val({tag, ".pc"}, ifid_pc, pc_exp);
    check_val({tag, ".pc4"}, ifid_pc_plus4, pc_exp + 32'd4);
    check_val({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
    check_val({tag, ".count"}, fetch_count, cnt_exp);
  endtask

  task automatic check_bubble(input string tag, input logic [9:0] addr_exp,
                              input logic [31:0] cnt_exp);
    check_val({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
    check_val({tag, ".instr"}, ifid_instruction, 32'd0);
    check_val({tag, ".addr"}, {22'd0, imem_address}, {22'd0, addr_exp});
    check_val({tag, ".count"}, fetch_count, cnt_exp);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clock);
    tick();
    // Reset state
    check_bubble("rst", 10'd0, 32'd0);
    check_val("rst.halted", {31'd0, halted}, 32'd0);
    check_val("rst.misalign", {31'd0, misalign_fault}, 32'd0);
    check_val("rst.pc", ifid_pc, 32'd0);

    // Sequential fetch of words 0..3
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_fetch("seq", 32'(4 * k), 32'h1000_0000 + 32'(k), 32'(k + 1));
    end
    check_val("seq.addr", {22'd0, imem_address}, 32'd4);

    // Stall three cycles at pc=0x10
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_fetch("stall", 32'd12, 32'h1000_0003, 32'd4);
      check_val("stall.addr", {22'd0, imem_address}, 32'd4);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("resume", 32'd16, 32'h1000_0004, 32'd5);

    // Redirect wins over stall
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    tick();
    check_bubble("redir", 10'd16, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("redir.tgt", 32'h40, 32'h1000_0010, 32'd6);
    check_val("redir.misalign", {31'd0, misalign_fault}, 32'd0);

    // Misaligned redirect: aligned down, sticky fault
    drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
    tick();
    check_bubble("mis", 10'd16, 32'd6);
    check_val("mis.flag", {31'd0, misalign_fault}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("mis.f0", 32'h40, 32'h1000_0010, 32'd7);
    tick();
    check_fetch("mis.f1", 32'h44, 32'h1000_0011, 32'd8);
    check_val("mis.sticky", {31'd0, misalign_fault}, 32'd1);

    // Halt at pc=0x20; stall asserted while halted is ignored
    drive(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check_bubble("halt", 10'd8, 32'd8);
    check_val("halt.halted", {31'd0, halted}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bubble("halted", 10'd8, 32'd8);
      check_val("halted.flag", {31'd0, halted}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check_bubble("unhalt", 10'd0, 32'd8);
    check_val("unhalt.halted", {31'd0, halted}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("unhalt.f0", 32'h0, 32'h1000_0000, 32'd9);

    // Memory address wrap at 0xFFC
    drive(1'b0, 1'b0, 1'b1, 32'hFFC, 1'b0);
    tick();
    check_bubble("wrap", 10'h3FF, 32'd9);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("wrap.f0", 32'hFFC, 32'h1000_03FF, 32'd10);
    check_val("wrap.addr", {22'd0, imem_address}, 32'd0);
    tick();
    check_fetch("wrap.f1", 32'h1000, 32'h1000_0000, 32'd11);

    // Full 32-bit PC wrap
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_val("pcwrap.pc", ifid_pc, 32'hFFFF_FFFC);
    check_val("pcwrap.pc4", ifid_pc_plus4, 32'd0);
    check_val("pcwrap.instr", ifid_instruction, 32'h1000_03FF);
    check_val("pcwrap.addr", {22'd0, imem_address}, 32'd0);
    check_val("pcwrap.count", fetch_count, 32'd12);

    // Reset while halted, together with a misaligned redirect
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    check_val("h2.halted", {31'd0, halted}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h82, 1'b1);
    tick();
    check_bubble("rst2", 10'd0, 32'd0);
    check_val("rst2.halted", {31'd0, halted}, 32'd0);
    check_val("rst2.misalign", {31'd0, misalign_fault}, 32'd0);
    check_val("rst2.pc", ifid_pc, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    check_fetch("rst2.f0", 32'h0, 32'h1000_0000, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
